// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA posted-write path: device code,
// store-size encodings, VRAM geometry and the serialiser state type.
package vga_pkg;

    localparam int VRAM_BYTES = 76800;
    localparam int VGA_ADDR_W = 17;

    localparam logic [2:0] DEVICE_ID_VGA = 3'd4;

    localparam logic [1:0] WS_WORD = 2'b00;
    localparam logic [1:0] WS_HALF = 2'b01;
    localparam logic [1:0] WS_BYTE = 2'b10;
    localparam logic [1:0] WS_NONE = 2'b11;

    // Queued entry layout, MSB first: {addr, data, size}
    localparam int VGA_ENTRY_W = VGA_ADDR_W + 32 + 2;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_t;

    // Index of the final byte lane for a given store size
    function automatic logic [1:0] last_byte_index(input logic [1:0] ws);
        case (ws)
            WS_WORD: return 2'd3;
            WS_HALF: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_write_buffer_fifo.sv
// Generic synchronous FIFO with a registered head-of-queue read; the head
// register is valid whenever the FIFO is not empty (first-word fall-through).
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = head_reg;

    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = pop_ok ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The head is re-read every cycle from the slot that will be at the front
    // next cycle; a push into that very slot is forwarded past the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vga_write_buffer.sv
// Posted-write buffer for the VGA video RAM: queues decoded CPU stores and
// replays each one as byte writes whenever the VRAM port is granted.
module vga_write_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int VRAM_BYTES = vga_pkg::VRAM_BYTES,
    parameter int ADDR_W     = vga_pkg::VGA_ADDR_W,
    parameter int DEVICE_ID  = int'(vga_pkg::DEVICE_ID_VGA)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        data_device,
    input  logic [31:0]       data_addr,
    input  logic              write_enable,
    input  logic [1:0]        window_size,
    input  logic              access_fault,
    input  logic [31:0]       write_data,
    output logic              stall,
    input  logic              vram_grant,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              empty,
    output logic [7:0]        drop_count
);

    localparam int ENTRY_W = ADDR_W + 32 + 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               req;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_in;
    logic [ENTRY_W-1:0] fifo_head;

    logic [ADDR_W-1:0]  head_addr;
    logic [31:0]        head_data;
    logic [1:0]         head_size;

    wb_state_t          state_reg;
    logic [1:0]         idx_reg;
    logic [1:0]         last_idx_reg;
    logic [ADDR_W:0]    cur_addr_reg;
    logic [31:0]        cur_data_reg;
    logic [7:0]         drop_count_reg;

    logic               in_range;
    logic               advance;
    logic               at_last;
    logic               load;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^data_addr[31:ADDR_W];

    // Request decode
    assign req = (data_device == 3'(DEVICE_ID)) && write_enable && (window_size != WS_NONE);

    // Full comes from the registered count only, so a slot freed this cycle
    // cannot be reused until the next one.
    assign fifo_push = req && !access_fault && !fifo_full;
    assign stall     = req && !access_fault && fifo_full;
    assign fifo_in   = {data_addr[ADDR_W-1:0], write_data, window_size};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_addr = fifo_head[ENTRY_W-1 -: ADDR_W];
    assign head_data = fifo_head[33:2];
    assign head_size = fifo_head[1:0];

    // The address register carries one spare bit so addr+idx never wraps back
    // into the valid window.
    assign in_range = (cur_addr_reg < (ADDR_W+1)'(VRAM_BYTES));
    assign advance  = (state_reg == WB_DRAIN) && (vram_grant || !in_range);
    assign at_last  = (idx_reg == last_idx_reg);
    assign load     = !fifo_empty && ((state_reg == WB_IDLE) || (advance && at_last));
    assign fifo_pop = load;

    assign vram_we    = (state_reg == WB_DRAIN) && vram_grant && in_range;
    assign vram_addr  = cur_addr_reg[ADDR_W-1:0];
    assign vram_wdata = cur_data_reg[7:0];
    assign empty      = (fifo_count == '0) && (state_reg == WB_IDLE);
    assign drop_count = drop_count_reg;

    // Serialiser: the current byte sits in the low lane of cur_data_reg and
    // the data shifts down one lane as the address steps up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= WB_IDLE;
            idx_reg      <= 2'd0;
            last_idx_reg <= 2'd0;
            cur_addr_reg <= '0;
            cur_data_reg <= '0;
        end else if (load) begin
            state_reg    <= WB_DRAIN;
            idx_reg      <= 2'd0;
            last_idx_reg <= last_byte_index(head_size);
            cur_addr_reg <= {1'b0, head_addr};
            cur_data_reg <= head_data;
        end else if (advance) begin
            if (at_last) begin
                state_reg <= WB_IDLE;
            end else begin
                idx_reg      <= idx_reg + 2'd1;
                cur_addr_reg <= cur_addr_reg + (ADDR_W+1)'(1);
                cur_data_reg <= {8'h00, cur_data_reg[31:8]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_reg <= 8'd0;
        end else if (req && access_fault && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_write_buffer.sv
// Directed bench for vga_write_buffer: inputs change on the falling edge,
// outputs are checked 1 time unit later, well clear of the rising edge.
module tb_vga_write_buffer;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  data_device;
    logic [31:0] data_addr;
    logic        write_enable;
    logic [1:0]  window_size;
    logic        access_fault;
    logic [31:0] write_data;
    logic        stall;
    logic        vram_grant;
    logic        vram_we;
    logic [16:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        empty;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    logic [24:0] wlog [$];
    logic [24:0] ent;
    logic [31:0] released;
    logic [31:0] release_cyc;

    always #5 clk = ~clk;

    vga_write_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .data_device  (data_device),
        .data_addr    (data_addr),
        .write_enable (write_enable),
        .window_size  (window_size),
        .access_fault (access_fault),
        .write_data   (write_data),
        .stall        (stall),
        .vram_grant   (vram_grant),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .empty        (empty),
        .drop_count   (drop_count)
    );

    // Byte-write log, one entry {addr, data} per strobed cycle
    always @(negedge clk) begin
        #2;
        if (vram_we === 1'b1) begin
            wlog.push_back({vram_addr, vram_wdata});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic store(input logic [2:0] dev, input logic [31:0] addr, input logic [1:0] ws,
                         input logic [31:0] data, input logic fault);
        data_device  = dev;
        data_addr    = addr;
        window_size  = ws;
        write_data   = data;
        access_fault = fault;
        write_enable = 1'b1;
    endtask

    task automatic no_req();
        write_enable = 1'b0;
        access_fault = 1'b0;
        window_size  = WS_NONE;
    endtask

    task automatic expw(input string tag, input logic [16:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(vram_we), 32'd1);
        chk({tag, "_addr"}, 32'(vram_addr), 32'(a));
        chk({tag, "_data"}, 32'(vram_wdata), 32'(d));
    endtask

    initial begin
        reset       = 1'b1;
        no_req();
        data_device = 3'd0;
        data_addr   = 32'd0;
        write_data  = 32'd0;
        vram_grant  = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_we", 32'(vram_we), 0);
        chk("rst_addr", 32'(vram_addr), 0);
        chk("rst_wdata", 32'(vram_wdata), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_drop", 32'(drop_count), 0);
        cyc();
        reset = 1'b0;

        // Word store, grant held high: bytes in cycles N+2..N+5
        cyc(); store(3'd4, 32'h10, WS_WORD, 32'hAABBCCDD, 1'b0); vram_grant = 1'b1;
        #1 chk("t1_stall", 32'(stall), 0);
        cyc(); no_req();
        #1 chk("t1_lat_we", 32'(vram_we), 0);
        chk("t1_busy", 32'(empty), 0);
        cyc(); #1 expw("t1_b0", 17'h10, 8'hDD);
        cyc(); #1 expw("t1_b1", 17'h11, 8'hCC);
        cyc(); #1 expw("t1_b2", 17'h12, 8'hBB);
        cyc(); #1 expw("t1_b3", 17'h13, 8'hAA);
        cyc(); #1 chk("t1_done_we", 32'(vram_we), 0);
        chk("t1_empty", 32'(empty), 1);

        // Half store at the top of VRAM with grant 1,0,1
        cyc(); store(3'd4, 32'h12BFE, WS_HALF, 32'h00001234, 1'b0);
        cyc(); no_req();
        cyc(); #1 expw("t2_b0", 17'h12BFE, 8'h34);
        cyc(); vram_grant = 1'b0;
        #1 chk("t2_nogrant_we", 32'(vram_we), 0);
        chk("t2_hold_addr", 32'(vram_addr), 32'h12BFF);
        cyc(); vram_grant = 1'b1;
        #1 expw("t2_b1", 17'h12BFF, 8'h12);
        cyc(); #1 chk("t2_done_we", 32'(vram_we), 0);
        chk("t2_empty", 32'(empty), 1);

        // Word straddling the end of VRAM: upper two bytes skipped silently
        cyc(); store(3'd4, 32'h12BFE, WS_WORD, 32'h44332211, 1'b0);
        cyc(); no_req();
        cyc(); #1 expw("tb_b0", 17'h12BFE, 8'h11);
        cyc(); #1 expw("tb_b1", 17'h12BFF, 8'h22);
        cyc(); #1 chk("tb_skip0_we", 32'(vram_we), 0);
        chk("tb_skip0_busy", 32'(empty), 0);
        cyc(); #1 chk("tb_skip1_we", 32'(vram_we), 0);
        cyc(); #1 chk("tb_empty", 32'(empty), 1);

        // Fill with grant low; the serialiser holds one entry, so the
        // FIFO fills on the tenth store.
        vram_grant = 1'b0;
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            cyc();
            store(3'd4, 32'h200 + 4*i, WS_WORD,
                  {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0);
            #1 chk($sformatf("t3_stall%0d", i), 32'(stall), 32'(i == 9));
        end
        repeat (2) begin
            cyc(); #1 chk("t3_hold_stall", 32'(stall), 1);
            chk("t3_hold_we", 32'(vram_we), 0);
        end
        cyc(); vram_grant = 1'b1;
        #1 chk("t3_first_we", 32'(vram_we), 1);
        chk("t3_first_stall", 32'(stall), 1);
        released    = 0;
        release_cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(); #1;
            if (stall === 1'b0) begin
                released    = 1;
                release_cyc = 32'(n);
                break;
            end
        end
        chk("t3_released", released, 1);
        chk("t3_release_cycle", release_cyc, 4);
        cyc(); no_req();
        for (int n = 0; n < 200; n++) begin
            if (empty === 1'b1) break;
            cyc(); #1;
        end
        chk("t3_drained", 32'(empty), 1);
        chk("t3_nbytes", 32'(wlog.size()), 40);
        for (int j = 0; j < 40; j++) begin
            ent = (j < wlog.size()) ? wlog[j] : 25'h0;
            chk($sformatf("t3_byte%0d", j), 32'(ent), 32'({17'(32'h200 + j), 8'(j)}));
        end

        // Ignored requests: no push, no stall, no drop
        cyc(); store(3'd4, 32'h40, WS_NONE, 32'h55, 1'b1);
        #1 chk("t6_ws11_stall", 32'(stall), 0);
        cyc(); store(3'd5, 32'h40, WS_BYTE, 32'h55, 1'b1);
        #1 chk("t6_dev5_stall", 32'(stall), 0);
        cyc(); store(3'd5, 32'h40, WS_BYTE, 32'h55, 1'b0);
        cyc(); no_req();
        #1 chk("t6_drop", 32'(drop_count), 0);
        chk("t6_empty0", 32'(empty), 1);
        cyc(); #1 chk("t6_empty1", 32'(empty), 1);
        chk("t6_we", 32'(vram_we), 0);

        // Faulting stores are dropped and counted, saturating at 255
        cyc(); store(3'd4, 32'h20, WS_BYTE, 32'hFF, 1'b1);
        #1 chk("t4_stall", 32'(stall), 0);
        cyc(); no_req();
        #1 chk("t4_drop1", 32'(drop_count), 1);
        chk("t4_empty", 32'(empty), 1);
        cyc(); store(3'd4, 32'h20, WS_BYTE, 32'hFF, 1'b1);
        repeat (253) cyc();
        #1 chk("t4_drop254", 32'(drop_count), 254);
        repeat (46) cyc();
        #1 chk("t4_drop_sat", 32'(drop_count), 255);
        no_req();

        // Reset in the middle of a word: the rest is abandoned
        cyc(); store(3'd4, 32'h300, WS_WORD, 32'h87654321, 1'b0);
        cyc(); no_req();
        cyc(); #1 expw("t5_b0", 17'h300, 8'h21);
        cyc(); #1 expw("t5_b1", 17'h301, 8'h43);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        #1 chk("t5_we", 32'(vram_we), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_addr", 32'(vram_addr), 0);
        chk("t5_drop", 32'(drop_count), 0);
        wlog.delete();
        repeat (10) cyc();
        #1 chk("t5_no_writes", 32'(wlog.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
